// File: rtl/pmod_ds2_pkg.sv
// Shared frame-buffer constants, arbiter state encoding and the pixel address helper.
package pmod_ds2_pkg;

  localparam int RD_H_DEF   = 480;
  localparam int RD_V_DEF   = 272;
  localparam int RD_LAT_DEF = 2;
  localparam int ADDR_W     = 17;
  localparam int DATA_W     = 16;
  localparam int COORD_W    = 10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  // Row-major word address, evaluated at full ADDR_W width so legal ranges never truncate.
  function automatic logic [ADDR_W-1:0] fb_addr(input logic [COORD_W-1:0] x,
                                                input logic [COORD_W-1:0] y,
                                                input int unsigned        h);
    return ADDR_W'(y) * ADDR_W'(h) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/fb_rd_pipe.sv
// Read-return tagging: a RD_LAT-deep valid/x delay line that aligns each SRAM
// return with its column and writes it into the line buffer one cycle later.
module fb_rd_pipe
  import pmod_ds2_pkg::*;
#(
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               rd_valid,
  input  logic [COORD_W-1:0] rd_x,
  input  logic [DATA_W-1:0]  rd_data,
  output logic               lb_we,
  output logic [COORD_W-1:0] lb_waddr,
  output logic [DATA_W-1:0]  lb_wdata
);

  logic [RD_LAT-1:0]  v_q, v_d;
  logic [COORD_W-1:0] x_q [RD_LAT];
  logic [COORD_W-1:0] x_d [RD_LAT];
  logic               lb_we_q, lb_we_d;
  logic [COORD_W-1:0] lb_waddr_q, lb_waddr_d;
  logic [DATA_W-1:0]  lb_wdata_q, lb_wdata_d;

  always_comb begin
    v_d    = '0;
    x_d    = '{default: '0};
    v_d[0] = rd_valid;
    x_d[0] = rd_x;
    for (int i = 1; i < RD_LAT; i++) begin
      v_d[i] = v_q[i-1];
      x_d[i] = x_q[i-1];
    end
    // The last stage lines up with mem_rdata for the read it tags.
    lb_we_d    = v_q[RD_LAT-1];
    lb_waddr_d = v_q[RD_LAT-1] ? x_q[RD_LAT-1] : '0;
    lb_wdata_d = v_q[RD_LAT-1] ? rd_data : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '0;
      for (int i = 0; i < RD_LAT; i++) x_q[i] <= '0;
      lb_we_q    <= 1'b0;
      lb_waddr_q <= '0;
      lb_wdata_q <= '0;
    end else begin
      v_q        <= v_d;
      x_q        <= x_d;
      lb_we_q    <= lb_we_d;
      lb_waddr_q <= lb_waddr_d;
      lb_wdata_q <= lb_wdata_d;
    end
  end

  assign lb_we    = lb_we_q;
  assign lb_waddr = lb_waddr_q;
  assign lb_wdata = lb_wdata_q;

endmodule

// File: rtl/fb_line_arbiter.sv
// Single-port frame-buffer arbiter: line prefetch has absolute priority, pixel writer
// uses idle cycles. Define FB_LINE_ARBITER_UNDERRUN_CNT_EN to add a saturating underrun_cnt.
module fb_line_arbiter
  import pmod_ds2_pkg::*;
#(
  parameter int RD_H   = RD_H_DEF,
  parameter int RD_V   = RD_V_DEF,
  parameter int RD_LAT = RD_LAT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               line_req,
  input  logic [COORD_W-1:0] line_y,
  input  logic               wr_valid,
  output logic               wr_ready,
  input  logic [COORD_W-1:0] wr_x,
  input  logic [COORD_W-1:0] wr_y,
  input  logic [DATA_W-1:0]  wr_data,
  output logic               mem_re,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               lb_we,
  output logic [COORD_W-1:0] lb_waddr,
  output logic [DATA_W-1:0]  lb_wdata,
  output logic               line_busy,
  output logic               underrun,
`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
  output logic [15:0]        underrun_cnt,
`endif
  output arb_state_e         dbg_state
);

  // Handshake: a pixel transfers on a cycle where wr_valid && wr_ready are both high at
  // the clock edge; wr_ready never depends on wr_valid.

  localparam logic [COORD_W-1:0] RD_H_L    = COORD_W'(RD_H);
  localparam logic [COORD_W-1:0] RD_V_L    = COORD_W'(RD_V);
  localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(RD_H - 1);
  localparam int                 DRN_W     = $clog2(RD_LAT + 2);
  localparam logic [DRN_W-1:0]   DRN_LAST  = DRN_W'(RD_LAT);

  arb_state_e         state_q, state_d;
  logic [COORD_W-1:0] x_q, x_d;
  logic [ADDR_W-1:0]  base_q, base_d;
  logic [DRN_W-1:0]   drain_q, drain_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  wr_addr_q, wr_addr_d;
  logic [DATA_W-1:0]  wr_data_q, wr_data_d;
  logic               fetch_go;
  logic               wr_fire;
  logic               wr_in_range;

  assign fetch_go    = line_req && (line_y < RD_V_L);
  assign wr_in_range = (wr_x < RD_H_L) && (wr_y < RD_V_L);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      x_q       <= '0;
      base_q    <= '0;
      drain_q   <= '0;
      mem_we_q  <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      x_q       <= x_d;
      base_q    <= base_d;
      drain_q   <= drain_d;
      mem_we_q  <= mem_we_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    base_d  = base_q;
    drain_d = drain_q;
    case (state_q)
      IDLE: begin
        if (fetch_go) begin
          state_d = FETCH;
          base_d  = fb_addr('0, line_y, RD_H);
          x_d     = '0;
        end
      end
      FETCH: begin
        if (x_q == X_LAST) begin
          state_d = DRAIN;
          drain_d = '0;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      DRAIN: begin
        // Holds RD_LAT+1 cycles: the last return lands in the line buffer on the final one.
        if (drain_q == DRN_LAST) state_d = IDLE;
        else                     drain_d = drain_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ready  = (state_q == IDLE) && !line_req;
    line_busy = (state_q != IDLE);
    underrun  = line_req && (state_q != IDLE);
    mem_re    = (state_q == FETCH);
    mem_we    = mem_we_q;
    mem_addr  = (state_q == FETCH) ? (base_q + ADDR_W'(x_q)) : wr_addr_q;
    mem_wdata = wr_data_q;
    dbg_state = state_q;
  end

  // Out-of-range pixels complete the handshake but never reach the SRAM.
  always_comb begin
    wr_fire   = wr_valid && wr_ready;
    mem_we_d  = wr_fire && wr_in_range;
    wr_addr_d = mem_we_d ? fb_addr(wr_x, wr_y, RD_H) : '0;
    wr_data_d = mem_we_d ? wr_data : '0;
  end

`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
  logic [15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (underrun && (cnt_q != 16'hFFFF)) cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign underrun_cnt = cnt_q;
`endif

  fb_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk      (clk),
    .rst      (rst),
    .rd_valid (mem_re),
    .rd_x     (x_q),
    .rd_data  (mem_rdata),
    .lb_we    (lb_we),
    .lb_waddr (lb_waddr),
    .lb_wdata (lb_wdata)
  );

endmodule

// File: tb/tb_fb_line_arbiter.sv
// Bench for fb_line_arbiter: SRAM read model, scoreboard monitor and per-scenario tasks.
module tb_fb_line_arbiter;
  import pmod_ds2_pkg::*;

  localparam int H   = 480;
  localparam int V   = 272;
  localparam int LAT = 2;

  logic               clk;
  logic               rst;
  logic               line_req;
  logic [COORD_W-1:0] line_y;
  logic               wr_valid;
  logic               wr_ready;
  logic [COORD_W-1:0] wr_x;
  logic [COORD_W-1:0] wr_y;
  logic [DATA_W-1:0]  wr_data;
  logic               mem_re;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [DATA_W-1:0]  mem_wdata;
  logic [DATA_W-1:0]  mem_rdata;
  logic               lb_we;
  logic [COORD_W-1:0] lb_waddr;
  logic [DATA_W-1:0]  lb_wdata;
  logic               line_busy;
  logic               underrun;
  arb_state_e         dbg_state;
`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
  logic [15:0]        underrun_cnt;
`endif

  int checks = 0;
  int errors = 0;
  bit mon_en = 1'b0;
  int exp_cnt = 0;

  logic [ADDR_W-1:0]         exp_rd_q[$];
  logic [COORD_W+DATA_W-1:0] exp_lb_q[$];
  logic [ADDR_W+DATA_W-1:0]  exp_wr_q[$];

  fb_line_arbiter #(.RD_H(H), .RD_V(V), .RD_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_req  (line_req),
    .line_y    (line_y),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_x      (wr_x),
    .wr_y      (wr_y),
    .wr_data   (wr_data),
    .mem_re    (mem_re),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .lb_we     (lb_we),
    .lb_waddr  (lb_waddr),
    .lb_wdata  (lb_wdata),
    .line_busy (line_busy),
    .underrun  (underrun),
`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
    .underrun_cnt (underrun_cnt),
`endif
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- SRAM read model ----------------
  function automatic logic [DATA_W-1:0] pix(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hA5C3 ^ {15'b0, a[16]};
  endfunction

  logic [DATA_W-1:0] rd_pipe [LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_re ? pix(mem_addr) : 16'h0;
    for (int i = 1; i < LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_rdata = rd_pipe[LAT-1];

  // ---------------- scoreboard monitor ----------------
  logic [ADDR_W-1:0]         m_rd;
  logic [COORD_W+DATA_W-1:0] m_lb;
  logic [ADDR_W+DATA_W-1:0]  m_wr;

  always @(negedge clk) begin
    if (mon_en) begin
      if (mem_re === 1'b1 && mem_we === 1'b1) begin
        checks++; errors++;
        $display("FAIL port_conflict mem_re and mem_we both high at %0t", $time);
      end
      if (mem_re === 1'b1) begin
        checks++;
        if (exp_rd_q.size() == 0) begin
          errors++; $display("FAIL sb_rd unexpected read addr=%0d", mem_addr);
        end else begin
          m_rd = exp_rd_q.pop_front();
          if (mem_addr !== m_rd) begin
            errors++; $display("FAIL sb_rd addr got=%0d exp=%0d", mem_addr, m_rd);
          end
        end
      end
      if (lb_we === 1'b1) begin
        checks++;
        if (exp_lb_q.size() == 0) begin
          errors++; $display("FAIL sb_lb unexpected lb_we x=%0d", lb_waddr);
        end else begin
          m_lb = exp_lb_q.pop_front();
          if ({lb_waddr, lb_wdata} !== m_lb) begin
            errors++;
            $display("FAIL sb_lb got x=%0d d=%h exp x=%0d d=%h", lb_waddr, lb_wdata,
                     m_lb[COORD_W+DATA_W-1:DATA_W], m_lb[DATA_W-1:0]);
          end
        end
      end
      if (mem_we === 1'b1) begin
        checks++;
        if (exp_wr_q.size() == 0) begin
          errors++; $display("FAIL sb_wr unexpected write addr=%0d", mem_addr);
        end else begin
          m_wr = exp_wr_q.pop_front();
          if ({mem_addr, mem_wdata} !== m_wr) begin
            errors++;
            $display("FAIL sb_wr got a=%0d d=%h exp a=%0d d=%h", mem_addr, mem_wdata,
                     m_wr[ADDR_W+DATA_W-1:DATA_W], m_wr[DATA_W-1:0]);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic push_fetch(input logic [COORD_W-1:0] y);
    logic [ADDR_W-1:0] a;
    for (int x = 0; x < H; x++) begin
      a = ADDR_W'(y) * ADDR_W'(H) + ADDR_W'(x);
      exp_rd_q.push_back(a);
      exp_lb_q.push_back({COORD_W'(x), pix(a)});
    end
  endtask

  task automatic do_fetch(input logic [COORD_W-1:0] y);
    logic exp_re, exp_lb, exp_busy;
    push_fetch(y);
    tick();
    line_req = 1'b1;
    line_y   = y;
    samp();
    checks++;
    if ({wr_ready, mem_re, line_busy, underrun} !== 4'b0000) begin
      errors++; $display("FAIL fetch_req_cycle rdy/re/busy/ur got=%b exp=0000",
                         {wr_ready, mem_re, line_busy, underrun});
    end
    for (int k = 1; k <= H + LAT + 3; k++) begin
      tick();
      line_req = 1'b0;
      samp();
      exp_re   = (k <= H);
      exp_lb   = (k >= LAT + 2) && (k <= H + LAT + 1);
      exp_busy = (k <= H + LAT + 1);
      checks++;
      if (mem_re !== exp_re) begin
        errors++; $display("FAIL fetch_mem_re k=%0d got=%b exp=%b", k, mem_re, exp_re);
      end
      checks++;
      if (lb_we !== exp_lb) begin
        errors++; $display("FAIL fetch_lb_we k=%0d got=%b exp=%b", k, lb_we, exp_lb);
      end
      checks++;
      if (line_busy !== exp_busy) begin
        errors++; $display("FAIL fetch_busy k=%0d got=%b exp=%b", k, line_busy, exp_busy);
      end
      checks++;
      if (wr_ready !== !exp_busy) begin
        errors++; $display("FAIL fetch_wr_ready k=%0d got=%b exp=%b", k, wr_ready, !exp_busy);
      end
    end
    checks++;
    if (exp_rd_q.size() != 0 || exp_lb_q.size() != 0) begin
      errors++; $display("FAIL fetch_drained left rd=%0d lb=%0d exp=0", exp_rd_q.size(), exp_lb_q.size());
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; line_req = 1'b0; line_y = '0;
    wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_data = '0;
    repeat (3) tick();
    samp();
    checks++;
    if ({mem_re, mem_we, lb_we, line_busy, underrun} !== 5'b0) begin
      errors++; $display("FAIL reset_strobes got=%b exp=00000", {mem_re, mem_we, lb_we, line_busy, underrun});
    end
    checks++;
    if ({mem_addr, mem_wdata, lb_waddr, lb_wdata} !== '0) begin
      errors++; $display("FAIL reset_buses addr=%0d wd=%h la=%0d ld=%h exp=0", mem_addr, mem_wdata, lb_waddr, lb_wdata);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE);
    end
`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'd0) begin
      errors++; $display("FAIL reset_cnt got=%0d exp=0", underrun_cnt);
    end
`endif
    tick();
    rst = 1'b0;
    mon_en = 1'b1;
    samp();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_wr_ready got=%b exp=1", wr_ready);
    end
  endtask

  task automatic test_write();
    tick();
    wr_valid = 1'b1; wr_x = 10'd5; wr_y = 10'd2; wr_data = 16'hF800;
    samp();
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++; $display("FAIL write_ready got=%b exp=1", wr_ready);
    end
    exp_wr_q.push_back({17'd965, 16'hF800});
    tick();
    wr_x = 10'd480; wr_y = 10'd0; wr_data = 16'h1234;
    samp();
    checks++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 17'd965, 16'hF800}) begin
      errors++; $display("FAIL write_first we=%b a=%0d d=%h exp we=1 a=965 d=f800", mem_we, mem_addr, mem_wdata);
    end
    tick();
    wr_x = 10'd0; wr_y = 10'd272;
    samp();
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL write_x_oob got=%b exp=0", mem_we);
    end
    tick();
    wr_valid = 1'b0;
    samp();
    checks++;
    if (mem_we !== 1'b0) begin
      errors++; $display("FAIL write_y_oob got=%b exp=0", mem_we);
    end
    for (int i = 0; i < 6; i++) begin
      tick();
      wr_valid = 1'b1;
      wr_x     = COORD_W'($urandom_range(H - 1, 0));
      wr_y     = COORD_W'($urandom_range(V - 1, 0));
      wr_data  = DATA_W'($urandom_range(16'hFFFF, 0));
      samp();
      checks++;
      if (wr_ready !== 1'b1) begin
        errors++; $display("FAIL b2b_ready i=%0d got=%b exp=1", i, wr_ready);
      end
      exp_wr_q.push_back({ADDR_W'(wr_y) * ADDR_W'(H) + ADDR_W'(wr_x), wr_data});
    end
    tick();
    wr_valid = 1'b0;
    tick();
    samp();
    checks++;
    if (exp_wr_q.size() != 0) begin
      errors++; $display("FAIL b2b_drained left=%0d exp=0", exp_wr_q.size());
    end
  endtask

  task automatic test_write_during_fetch();
    logic [COORD_W-1:0] px [6];
    logic [COORD_W-1:0] py [6];
    logic [DATA_W-1:0]  pd [6];
    int   idx = 0;
    logic exp_rdy;
    for (int i = 0; i < 6; i++) begin
      px[i] = COORD_W'($urandom_range(H - 1, 0));
      py[i] = COORD_W'($urandom_range(V - 1, 0));
      pd[i] = DATA_W'($urandom_range(16'hFFFF, 0));
    end
    push_fetch(10'd100);
    for (int k = 0; k < H + LAT + 20; k++) begin
      tick();
      line_req = (k == 0);
      line_y   = 10'd100;
      wr_valid = (idx < 6);
      if (idx < 6) begin
        wr_x = px[idx]; wr_y = py[idx]; wr_data = pd[idx];
      end
      samp();
      exp_rdy = (k >= H + LAT + 2);
      checks++;
      if (wr_ready !== exp_rdy) begin
        errors++; $display("FAIL hold_wr_ready k=%0d got=%b exp=%b", k, wr_ready, exp_rdy);
      end
      if (exp_rdy && idx < 6) begin
        exp_wr_q.push_back({ADDR_W'(py[idx]) * ADDR_W'(H) + ADDR_W'(px[idx]), pd[idx]});
        idx++;
      end
    end
    wr_valid = 1'b0;
    checks++;
    if (exp_rd_q.size() != 0 || exp_lb_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++; $display("FAIL hold_drained rd=%0d lb=%0d wr=%0d exp=0", exp_rd_q.size(), exp_lb_q.size(), exp_wr_q.size());
    end
  endtask

  task automatic test_underrun();
    logic exp_u;
    push_fetch(10'd50);
    for (int k = 0; k <= H + LAT + 3; k++) begin
      tick();
      line_req = (k == 0) || (k == 100);
      line_y   = (k == 0) ? 10'd50 : 10'd60;
      samp();
      exp_u = (k == 100);
      checks++;
      if (underrun !== exp_u) begin
        errors++; $display("FAIL underrun_pulse k=%0d got=%b exp=%b", k, underrun, exp_u);
      end
      if (exp_u) exp_cnt++;
    end
    line_req = 1'b0;
    checks++;
    if (exp_rd_q.size() != 0 || exp_lb_q.size() != 0) begin
      errors++; $display("FAIL underrun_fetch left rd=%0d lb=%0d exp=0", exp_rd_q.size(), exp_lb_q.size());
    end
`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL underrun_cnt got=%0d exp=%0d", underrun_cnt, exp_cnt);
    end
`endif
  endtask

  task automatic test_bad_line();
    tick();
    line_req = 1'b1;
    line_y   = 10'd272;
    samp();
    checks++;
    if ({wr_ready, underrun} !== 2'b00) begin
      errors++; $display("FAIL bad_line_req rdy/ur got=%b exp=00", {wr_ready, underrun});
    end
    for (int k = 1; k <= 5; k++) begin
      tick();
      line_req = 1'b0;
      samp();
      checks++;
      if ({mem_re, line_busy, underrun} !== 3'b000) begin
        errors++; $display("FAIL bad_line k=%0d re/busy/ur got=%b exp=000", k, {mem_re, line_busy, underrun});
      end
    end
  endtask

  task automatic test_reset_mid();
    push_fetch(10'd10);
    tick();
    line_req = 1'b1;
    line_y   = 10'd10;
    for (int k = 1; k <= 50; k++) begin
      tick();
      line_req = 1'b0;
    end
    rst = 1'b1;
    samp();
    tick();
    rst = 1'b0;
    exp_rd_q.delete();
    exp_lb_q.delete();
    exp_cnt = 0;
    samp();
    checks++;
    if ({mem_re, mem_we, lb_we, line_busy, underrun} !== 5'b0) begin
      errors++; $display("FAIL rst_mid_strobes got=%b exp=00000", {mem_re, mem_we, lb_we, line_busy, underrun});
    end
    checks++;
    if ({mem_addr, mem_wdata, lb_waddr, lb_wdata} !== '0) begin
      errors++; $display("FAIL rst_mid_buses addr=%0d la=%0d exp=0", mem_addr, lb_waddr);
    end
    checks++;
    if (dbg_state !== IDLE) begin
      errors++; $display("FAIL rst_mid_state got=%0d exp=%0d", dbg_state, IDLE);
    end
`ifdef FB_LINE_ARBITER_UNDERRUN_CNT_EN
    checks++;
    if (underrun_cnt !== 16'(exp_cnt)) begin
      errors++; $display("FAIL rst_mid_cnt got=%0d exp=%0d", underrun_cnt, exp_cnt);
    end
`endif
    for (int k = 0; k < LAT + 3; k++) begin
      tick();
      samp();
      checks++;
      if ({lb_we, mem_re} !== 2'b00) begin
        errors++; $display("FAIL rst_mid_stale k=%0d lb_we/re got=%b exp=00", k, {lb_we, mem_re});
      end
    end
    do_fetch(10'd20);
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    test_reset();
    do_fetch(10'd3);
    test_write();
    test_write_during_fetch();
    test_underrun();
    test_bad_line();
    test_reset_mid();
    repeat (4) tick();
    samp();
    checks++;
    if (exp_rd_q.size() != 0 || exp_lb_q.size() != 0 || exp_wr_q.size() != 0) begin
      errors++; $display("FAIL final_queues rd=%0d lb=%0d wr=%0d exp=0", exp_rd_q.size(), exp_lb_q.size(), exp_wr_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
